// File: rtl/ex_mem_buffer.sv
// EX->MEM elastic pipeline register: 2-entry skid buffer (head H, skid S) with head forwarding.
// Optional saturating stall counter port enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              write_or_not,
  input  logic [DATA_W-1:0] wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] dest_addr_output,
  output logic              write_or_not_output,
  output logic [DATA_W-1:0] wdata_output,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [ADDR_W-1:0]   h_addr_q, h_addr_d, s_addr_q, s_addr_d;
  logic                h_we_q, h_we_d, s_we_q, s_we_d;
  logic [DATA_W-1:0]   h_data_q, h_data_d, s_data_q, s_data_d;

  logic accept, drain, cap_we;

  assign accept = in_valid & in_ready_q;
  assign drain  = (state_q != StEmpty) & out_ready;
  // Writes to the zero register are dropped at capture; data is still kept.
  assign cap_we = write_or_not & (dest_addr != '0);

  always_comb begin
    state_d  = state_q;
    h_addr_d = h_addr_q;
    h_we_d   = h_we_q;
    h_data_d = h_data_q;
    s_addr_d = s_addr_q;
    s_we_d   = s_we_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d = StEmpty;
      h_we_d  = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d  = StOne;
            h_addr_d = dest_addr;
            h_we_d   = cap_we;
            h_data_d = wdata;
          end
        end
        StOne: begin
          if (accept && drain) begin
            h_addr_d = dest_addr;
            h_we_d   = cap_we;
            h_data_d = wdata;
          end else if (accept) begin
            state_d  = StTwo;
            s_addr_d = dest_addr;
            s_we_d   = cap_we;
            s_data_d = wdata;
          end else if (drain) begin
            state_d = StEmpty;
            h_we_d  = 1'b0;
          end
        end
        StTwo: begin
          if (drain) begin
            state_d  = StOne;
            h_addr_d = s_addr_q;
            h_we_d   = s_we_q;
            h_data_d = s_data_q;
          end
        end
        default: begin
          state_d = StEmpty;
          h_we_d  = 1'b0;
        end
      endcase
    end
    // Registered so in_ready has no combinational path from out_ready.
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      h_addr_q   <= '0;
      h_we_q     <= 1'b0;
      h_data_q   <= '0;
      s_addr_q   <= '0;
      s_we_q     <= 1'b0;
      s_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      h_addr_q   <= h_addr_d;
      h_we_q     <= h_we_d;
      h_data_q   <= h_data_d;
      s_addr_q   <= s_addr_d;
      s_we_q     <= s_we_d;
      s_data_q   <= s_data_d;
    end
  end

  assign in_ready            = in_ready_q;
  assign out_valid           = (state_q != StEmpty);
  assign dest_addr_output    = h_addr_q;
  assign write_or_not_output = h_we_q & out_valid;
  assign wdata_output        = h_data_q;
  assign fwd_valid           = write_or_not_output;
  assign fwd_addr            = h_addr_q;
  assign fwd_data            = h_data_q;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Scoreboard bench for ex_mem_buffer: driver pushes expected entries into a FIFO model,
// a negedge monitor compares the head and pops on each drain.
module tb_ex_mem_buffer;

  logic        clk, rst, flush, in_valid, in_ready, write_or_not, out_valid, out_ready;
  logic [4:0]  dest_addr, dest_addr_output, fwd_addr;
  logic [31:0] wdata, wdata_output, fwd_data;
  logic        write_or_not_output, fwd_valid;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] stall_m;
`endif

  ex_mem_buffer #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .dest_addr           (dest_addr),
    .write_or_not        (write_or_not),
    .wdata               (wdata),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .dest_addr_output    (dest_addr_output),
    .write_or_not_output (write_or_not_output),
    .wdata_output        (wdata_output),
    .fwd_valid           (fwd_valid),
    .fwd_addr            (fwd_addr),
    .fwd_data            (fwd_data)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_count         (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic        w;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: head of the model FIFO must be what the DUT presents.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        chk("dest_addr_output", 64'(dest_addr_output), 64'(q[0].a));
        chk("write_or_not_output", 64'(write_or_not_output), 64'(q[0].w));
        chk("wdata_output", 64'(wdata_output), 64'(q[0].d));
        chk("fwd_valid", 64'(fwd_valid), 64'(q[0].w));
        chk("fwd_addr", 64'(fwd_addr), 64'(q[0].a));
        chk("fwd_data", 64'(fwd_data), 64'(q[0].d));
      end else begin
        chk("we_when_idle", 64'(write_or_not_output), 64'd0);
        chk("fwd_valid_when_idle", 64'(fwd_valid), 64'd0);
      end
`ifdef EX_MEM_STALL_CNT_EN
      chk("stall_count", 64'(stall_count), 64'(stall_m));
      if (rst) stall_m = 32'd0;
      else if (q.size() != 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
`endif
      if (out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  // Driver: set inputs after the edge, record the accept just after the monitor has run.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [4:0] a, input bit w,
                     input logic [31:0] d, input bit ordy);
    @(posedge clk);
    #1;
    rst = r; flush = f; in_valid = iv; dest_addr = a; write_or_not = w; wdata = d;
    out_ready = ordy;
    @(negedge clk);
    #1;
    if (r || f) q.delete();
    else if (iv && in_ready) q.push_back('{a, w && (a != 5'd0), d});
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, ordy);
  endtask

  task automatic push(input logic [4:0] a, input bit w, input logic [31:0] d, input bit ordy);
    cyc(1'b0, 1'b0, 1'b1, a, w, d, ordy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; dest_addr = '0; write_or_not = 1'b0;
    wdata = '0; out_ready = 1'b0;
`ifdef EX_MEM_STALL_CNT_EN
    stall_m = 32'd0;
`endif
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_addr", 64'(dest_addr_output), 64'd0);
    chk("reset_wdata", 64'(wdata_output), 64'd0);
    chk("reset_fwd_valid", 64'(fwd_valid), 64'd0);
    mon_en = 1'b1;

    // Single entry.
    push(5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // Backpressure fill then release.
    push(5'd1, 1'b1, 32'd1, 1'b0);
    push(5'd2, 1'b1, 32'd2, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    // Streaming.
    for (int i = 0; i < 8; i++) push(5'(i + 1), 1'b1, 32'(i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    // Zero register.
    push(5'd0, 1'b1, 32'h1234, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // Flush with simultaneous accept while full.
    push(5'd3, 1'b1, 32'h33, 1'b0);
    push(5'd4, 1'b1, 32'h44, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 32'h66, 1'b0);
    idle(1'b1);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);
    // Stall for 10 cycles, then reset mid-operation.
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    push(5'd7, 1'b1, 32'h77, 1'b0);
    for (int i = 0; i < 11; i++) idle(1'b0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("stall_count_10", 64'(stall_count), 64'd10);
`endif
    cyc(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 32'h99, 1'b0);
    idle(1'b0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_addr", 64'(dest_addr_output), 64'd0);
    chk("midrst_wdata", 64'(wdata_output), 64'd0);
    chk("midrst_we", 64'(write_or_not_output), 64'd0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("midrst_stall_count", 64'(stall_count), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 200) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
          (($urandom % 4) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), $urandom,
          ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
